// File: rtl/idecode_q_if.sv
// IF push, EX issue and register-file signals of the queued decode stage.
`include "idecode_if_defs.svh"

interface idecode_q_if #(
  parameter int unsigned WORD  = `WORD,
  parameter int unsigned ADDR  = 32,
  parameter int unsigned W_CNT = 16
);
  logic                 v_i;
  logic                 stall_o;
  logic [WORD-1:0]      inst_i;
  logic [ADDR-1:0]      origaddr_i;
  logic                 flush_i;
  logic [WORD-1:0]      src_o;
  logic [WORD-1:0]      dest_o;
  logic                 wb_o;
  logic [`W_RD-1:0]     wb_rd_name_o;
  logic [`W_DOPC-1:0]   dopc_o;
  logic [`W_OPC-1:0]    opc_o;
  logic [ADDR-1:0]      origaddr_o;
  logic [`W_CC-1:0]     cc_o;
  logic                 v_o;
  logic                 stall_i;
  logic                 rd_reserve_o;
  logic [`W_RD-1:0]     rd_name_o;
  logic [`W_RD-1:0]     rs_name_o;
  logic [WORD-1:0]      rd_data_i;
  logic [WORD-1:0]      rs_data_i;
  logic                 rd_reserved_i;
  logic                 rs_reserved_i;
  logic [W_CNT-1:0]     hazard_cnt_o;

  modport slave (
    input  v_i, inst_i, origaddr_i, flush_i, stall_i,
           rd_data_i, rs_data_i, rd_reserved_i, rs_reserved_i,
    output stall_o, src_o, dest_o, wb_o, wb_rd_name_o, dopc_o, opc_o,
           origaddr_o, cc_o, v_o, rd_reserve_o, rd_name_o, rs_name_o, hazard_cnt_o
  );

  modport master (
    output v_i, inst_i, origaddr_i, flush_i, stall_i,
           rd_data_i, rs_data_i, rd_reserved_i, rs_reserved_i,
    input  stall_o, src_o, dest_o, wb_o, wb_rd_name_o, dopc_o, opc_o,
           origaddr_o, cc_o, v_o, rd_reserve_o, rd_name_o, rs_name_o, hazard_cnt_o
  );
endinterface

// File: rtl/idecode_if_defs.svh
// Shared instruction-format macros for the queued decode stage and its bus interface.
`ifndef IDECODE_Q_DEFS
`define IDECODE_Q_DEFS
`define WORD   32
`define W_OPC  6
`define W_DOPC 4
`define W_RD   5
`define W_CC   4
`define OPC    31:26
`define IMMF   25
`define RD     24:20
`define RS     19:15
`define IMM    15:0
`endif

// File: rtl/idecode_q.sv
// Queued decode stage: DEPTH-entry {inst, addr} ring between IF and EX, head decode,
// register-file read, reservation hazard check and a saturating hazard-stall counter.
`include "idecode_if_defs.svh"

module idecode_q #(
  parameter int unsigned WORD  = `WORD,
  parameter int unsigned ADDR  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W_CNT = 16
) (
  input logic        clk,
  input logic        rst,
  idecode_q_if.slave bus
);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned W_IMM = 16;

  localparam logic [`W_OPC-1:0] OP_ADD = 6'h01;
  localparam logic [`W_OPC-1:0] OP_SUB = 6'h02;
  localparam logic [`W_OPC-1:0] OP_AND = 6'h03;
  localparam logic [`W_OPC-1:0] OP_OR  = 6'h04;
  localparam logic [`W_OPC-1:0] OP_LUI = 6'h05;
  localparam logic [`W_OPC-1:0] OP_LD  = 6'h06;
  localparam logic [`W_OPC-1:0] OP_ST  = 6'h07;
  localparam logic [`W_OPC-1:0] OP_BR  = 6'h08;
  localparam logic [`W_OPC-1:0] OP_CMP = 6'h09;

  localparam logic [`W_DOPC-1:0] D_NOP = 4'd0;
  localparam logic [`W_DOPC-1:0] D_ADD = 4'd1;
  localparam logic [`W_DOPC-1:0] D_SUB = 4'd2;
  localparam logic [`W_DOPC-1:0] D_AND = 4'd3;
  localparam logic [`W_DOPC-1:0] D_OR  = 4'd4;
  localparam logic [`W_DOPC-1:0] D_LUI = 4'd5;
  localparam logic [`W_DOPC-1:0] D_LD  = 4'd6;
  localparam logic [`W_DOPC-1:0] D_ST  = 4'd7;
  localparam logic [`W_DOPC-1:0] D_BR  = 4'd8;
  localparam logic [`W_DOPC-1:0] D_CMP = 4'd9;

  function automatic logic [`W_DOPC-1:0] decode_ope(input logic [`W_OPC-1:0] opc);
    logic [`W_DOPC-1:0] d;
    case (opc)
      OP_ADD:  d = D_ADD;
      OP_SUB:  d = D_SUB;
      OP_AND:  d = D_AND;
      OP_OR:   d = D_OR;
      OP_LUI:  d = D_LUI;
      OP_LD:   d = D_LD;
      OP_ST:   d = D_ST;
      OP_BR:   d = D_BR;
      OP_CMP:  d = D_CMP;
      default: d = D_NOP;
    endcase
    return d;
  endfunction

  // Logical ops zero-extend, LUI places the field in the upper half, the rest sign-extend.
  function automatic logic [WORD-1:0] expand_imm(input logic [`W_OPC-1:0] opc,
                                                 input logic [W_IMM-1:0]  imm);
    logic [WORD-1:0] r;
    case (opc)
      OP_LUI:        r = WORD'({imm, 16'h0000});
      OP_AND, OP_OR: r = WORD'(imm);
      default:       r = WORD'($signed(imm));
    endcase
    return r;
  endfunction

  function automatic logic wb_required(input logic [`W_DOPC-1:0] dopc);
    logic w;
    case (dopc)
      D_ADD, D_SUB, D_AND, D_OR, D_LUI, D_LD: w = 1'b1;
      default:                                w = 1'b0;
    endcase
    return w;
  endfunction

  logic [WORD-1:0]    q_inst [DEPTH];
  logic [ADDR-1:0]    q_addr [DEPTH];
  logic [AW-1:0]      rd_ptr, wr_ptr;
  logic [AW:0]        count;
  logic               full, push, hazard, accept, issue, blocked, nonempty;

  logic [WORD-1:0]    head;
  logic [`W_OPC-1:0]  h_opc;
  logic               h_immf;
  logic [`W_RD-1:0]   h_rd, h_rs;
  logic [W_IMM-1:0]   h_imm;
  logic [`W_DOPC-1:0] h_dopc;
  logic               h_wb;

  logic                 v_q, wb_q;
  logic [WORD-1:0]      src_q, dest_q;
  logic [`W_RD-1:0]     wb_rd_q;
  logic [`W_DOPC-1:0]   dopc_q;
  logic [`W_OPC-1:0]    opc_q;
  logic [ADDR-1:0]      addr_q;
  logic [`W_CC-1:0]     cc_q;
  logic [W_CNT-1:0]     hcnt_q;

  // Head decode and issue control.
  assign head     = q_inst[rd_ptr];
  assign h_opc    = head[`OPC];
  assign h_immf   = head[`IMMF];
  assign h_rd     = head[`RD];
  assign h_rs     = head[`RS];
  assign h_imm    = head[`IMM];
  assign h_dopc   = decode_ope(h_opc);
  assign h_wb     = wb_required(h_dopc);

  assign full     = (count == (AW+1)'(DEPTH));
  assign nonempty = (count != '0);
  assign push     = bus.v_i & ~full & ~bus.flush_i;
  assign hazard   = bus.rd_reserved_i | (~h_immf & bus.rs_reserved_i);
  assign accept   = ~(v_q & bus.stall_i);
  assign issue    = nonempty & ~hazard & accept & ~bus.flush_i;
  assign blocked  = nonempty & hazard & accept & ~bus.flush_i;

  // Queue storage needs no reset: entries are only read while count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[wr_ptr] <= bus.inst_i;
      q_addr[wr_ptr] <= bus.origaddr_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + AW'(1);
      if (issue) rd_ptr <= rd_ptr + AW'(1);
      if (push && !issue)      count <= count + (AW+1)'(1);
      else if (!push && issue) count <= count - (AW+1)'(1);
    end
  end

  // Issue register; flush clears valid even while EX is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q     <= 1'b0;
      src_q   <= '0;
      dest_q  <= '0;
      wb_q    <= 1'b0;
      wb_rd_q <= '0;
      dopc_q  <= '0;
      opc_q   <= '0;
      addr_q  <= '0;
      cc_q    <= '0;
    end else if (bus.flush_i) begin
      v_q <= 1'b0;
    end else if (issue) begin
      v_q     <= 1'b1;
      src_q   <= h_immf ? expand_imm(h_opc, h_imm) : bus.rs_data_i;
      dest_q  <= bus.rd_data_i;
      wb_q    <= h_wb;
      wb_rd_q <= h_rd;
      dopc_q  <= h_dopc;
      opc_q   <= h_opc;
      addr_q  <= q_addr[rd_ptr];
      cc_q    <= h_rd[`W_CC-1:0];
    end else if (accept) begin
      v_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      hcnt_q <= '0;
    else if (blocked && ~&hcnt_q)  hcnt_q <= hcnt_q + W_CNT'(1);
  end

  assign bus.stall_o      = full;
  assign bus.rd_reserve_o = issue & h_wb;
  assign bus.rd_name_o    = h_rd;
  assign bus.rs_name_o    = h_rs;
  assign bus.v_o          = v_q;
  assign bus.src_o        = src_q;
  assign bus.dest_o       = dest_q;
  assign bus.wb_o         = wb_q;
  assign bus.wb_rd_name_o = wb_rd_q;
  assign bus.dopc_o       = dopc_q;
  assign bus.opc_o        = opc_q;
  assign bus.origaddr_o   = addr_q;
  assign bus.cc_o         = cc_q;
  assign bus.hazard_cnt_o = hcnt_q;
endmodule

// File: tb/tb_idecode_q.sv
// Directed bench for idecode_q: per-instruction decode table plus burst, hazard, flush and reset sequences.
`timescale 1ns/1ps
module tb_idecode_q;
  logic clk;
  logic rst;

  idecode_q_if #(.WORD(32), .ADDR(32), .W_CNT(16)) bus ();
  idecode_q_if #(.WORD(32), .ADDR(32), .W_CNT(2))  bus2 ();

  idecode_q #(.WORD(32), .ADDR(32), .DEPTH(4), .W_CNT(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  idecode_q #(.WORD(32), .ADDR(32), .DEPTH(4), .W_CNT(2)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  // The narrow-counter instance sees identical stimulus.
  assign bus2.v_i           = bus.v_i;
  assign bus2.inst_i        = bus.inst_i;
  assign bus2.origaddr_i    = bus.origaddr_i;
  assign bus2.flush_i       = bus.flush_i;
  assign bus2.stall_i       = bus.stall_i;
  assign bus2.rd_data_i     = bus.rd_data_i;
  assign bus2.rs_data_i     = bus.rs_data_i;
  assign bus2.rd_reserved_i = bus.rd_reserved_i;
  assign bus2.rs_reserved_i = bus.rs_reserved_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] rd_data;
    logic [31:0] rs_data;
    logic [31:0] exp_src;
    logic        exp_wb;
    logic [3:0]  exp_dopc;
    logic [3:0]  exp_cc;
    logic [4:0]  exp_rd;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] got [$];
  bit          mon_en = 1'b0;

  // Record every address EX actually takes.
  always @(negedge clk) begin
    if (mon_en && bus.v_o && !bus.stall_i) got.push_back(bus.origaddr_o);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_add(input logic [4:0] rd, input logic [4:0] rs);
    logic [5:0] opc;
    opc = 6'h01;
    return {opc, 1'b0, rd, rs, 15'h0000};
  endfunction

  task automatic drive_push(input logic [31:0] inst, input logic [31:0] addr);
    bus.v_i        = 1'b1;
    bus.inst_i     = inst;
    bus.origaddr_i = addr;
    @(posedge clk); #1;
    bus.v_i = 1'b0;
  endtask

  task automatic burst_round(input logic [31:0] base);
    logic [31:0] exp_a;
    bus.stall_i = 1'b0;
    @(posedge clk); #1;
    got.delete();
    mon_en = 1'b1;
    bus.stall_i = 1'b1;
    drive_push(mk_add(5'd1, 5'd2), base - 32'd4);
    @(posedge clk); #1;
    chk("burst_lead_v", bus.v_o, 1);
    for (int k = 0; k < 4; k++) drive_push(mk_add(5'(k), 5'd2), base + 32'(4 * k));
    chk("burst_full", bus.stall_o, 1);
    bus.v_i = 1'b1;
    bus.inst_i = mk_add(5'd4, 5'd2);
    bus.origaddr_i = base + 32'd16;
    @(posedge clk); #1;
    chk("burst_held", bus.stall_o, 1);
    bus.stall_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.v_i = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    mon_en = 1'b0;
    chk("burst_count", 64'(got.size()), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      exp_a = base - 32'd4 + 32'(4 * i);
      chk($sformatf("burst_order_%0h_%0d", base, i), got[i], exp_a);
    end
  endtask

  initial begin
    vec_t        v;
    logic [31:0] t;

    //           inst          addr        rd_data     rs_data     exp_src       wb    dopc  cc    rd
    vecs[0] = '{32'h0411_0000, 32'h100, 32'h5,  32'h7,  32'h0000_0007, 1'b1, 4'd1, 4'd1, 5'd1}; // ADD r1,r2
    vecs[1] = '{32'h0630_FFFE, 32'h104, 32'h11, 32'h22, 32'hFFFF_FFFE, 1'b1, 4'd1, 4'd3, 5'd3}; // ADDI r3,-2
    vecs[2] = '{32'h1640_1234, 32'h108, 32'h33, 32'h44, 32'h1234_0000, 1'b1, 4'd5, 4'd4, 5'd4}; // LUI r4
    vecs[3] = '{32'h1250_8001, 32'h10C, 32'h55, 32'h66, 32'h0000_8001, 1'b1, 4'd4, 4'd5, 5'd5}; // ORI r5
    vecs[4] = '{32'h1C63_8000, 32'h110, 32'hBB, 32'hAA, 32'h0000_00AA, 1'b0, 4'd7, 4'd6, 5'd6}; // ST r6,r7
    vecs[5] = '{32'h2290_0010, 32'h114, 32'h1,  32'h2,  32'h0000_0010, 1'b0, 4'd8, 4'd9, 5'd9}; // BR cc9
    vecs[6] = '{32'hFC21_8000, 32'h118, 32'h77, 32'h88, 32'h0000_0088, 1'b0, 4'd0, 4'd2, 5'd2}; // unknown

    rst = 1'b0;
    bus.v_i = 1'b0; bus.inst_i = '0; bus.origaddr_i = '0; bus.flush_i = 1'b0;
    bus.stall_i = 1'b0; bus.rd_data_i = '0; bus.rs_data_i = '0;
    bus.rd_reserved_i = 1'b0; bus.rs_reserved_i = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;

    chk("rst_v", bus.v_o, 0);
    chk("rst_src", bus.src_o, 0);
    chk("rst_dest", bus.dest_o, 0);
    chk("rst_wb", bus.wb_o, 0);
    chk("rst_wbrd", bus.wb_rd_name_o, 0);
    chk("rst_dopc", bus.dopc_o, 0);
    chk("rst_opc", bus.opc_o, 0);
    chk("rst_addr", bus.origaddr_o, 0);
    chk("rst_cc", bus.cc_o, 0);
    chk("rst_hcnt", bus.hazard_cnt_o, 0);
    chk("rst_stall", bus.stall_o, 0);
    chk("rst_rsv", bus.rd_reserve_o, 0);

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      t = v.inst;
      bus.rd_data_i = v.rd_data;
      bus.rs_data_i = v.rs_data;
      drive_push(v.inst, v.addr);
      chk($sformatf("v%0d_rsv", i), bus.rd_reserve_o, v.exp_wb);
      chk($sformatf("v%0d_rdname", i), bus.rd_name_o, v.exp_rd);
      @(posedge clk); #1;
      chk($sformatf("v%0d_v", i), bus.v_o, 1);
      chk($sformatf("v%0d_src", i), bus.src_o, v.exp_src);
      chk($sformatf("v%0d_dest", i), bus.dest_o, v.rd_data);
      chk($sformatf("v%0d_wb", i), bus.wb_o, v.exp_wb);
      chk($sformatf("v%0d_wbrd", i), bus.wb_rd_name_o, v.exp_rd);
      chk($sformatf("v%0d_dopc", i), bus.dopc_o, v.exp_dopc);
      chk($sformatf("v%0d_opc", i), bus.opc_o, t[31:26]);
      chk($sformatf("v%0d_cc", i), bus.cc_o, v.exp_cc);
      chk($sformatf("v%0d_addr", i), bus.origaddr_o, v.addr);
    end

    burst_round(32'h100);
    burst_round(32'h200);
    burst_round(32'h300);

    // Immediate form ignores rs reservation; register form blocks on it.
    bus.rd_data_i = 32'h5;
    bus.rs_data_i = 32'h7;
    bus.rs_reserved_i = 1'b1;
    drive_push(32'h0630_FFFE, 32'h800);
    chk("immf_rsv", bus.rd_reserve_o, 1);
    @(posedge clk); #1;
    chk("immf_v", bus.v_o, 1);
    chk("immf_src", bus.src_o, 32'hFFFF_FFFE);
    drive_push(mk_add(5'd1, 5'd2), 32'h804);
    chk("rs_haz_rsv", bus.rd_reserve_o, 0);
    @(posedge clk); #1;
    chk("rs_haz_v", bus.v_o, 0);
    chk("rs_haz_cnt", bus.hazard_cnt_o, 1);
    bus.rs_reserved_i = 1'b0;
    bus.rd_reserved_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("rd_haz_rsv%0d", c), bus.rd_reserve_o, 0);
    end
    chk("rd_haz_cnt", bus.hazard_cnt_o, 4);
    chk("sat_cnt", bus2.hazard_cnt_o, 3);
    bus.rd_reserved_i = 1'b0;
    #1;
    chk("haz_clear_rsv", bus.rd_reserve_o, 1);
    @(posedge clk); #1;
    chk("haz_clear_v", bus.v_o, 1);
    chk("haz_clear_addr", bus.origaddr_o, 32'h804);
    chk("haz_clear_src", bus.src_o, 32'h7);

    // Flush with EX stalled and IF pushing: valid must still drop.
    bus.stall_i = 1'b0;
    @(posedge clk); #1;
    bus.stall_i = 1'b1;
    drive_push(mk_add(5'd1, 5'd2), 32'h400);
    @(posedge clk); #1;
    for (int k = 1; k < 4; k++) drive_push(mk_add(5'd1, 5'd2), 32'h400 + 32'(4 * k));
    chk("fl1_pre_v", bus.v_o, 1);
    chk("fl1_pre_stall", bus.stall_o, 0);
    bus.flush_i = 1'b1;
    bus.v_i = 1'b1;
    bus.origaddr_i = 32'h410;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    bus.v_i = 1'b0;
    chk("fl1_v", bus.v_o, 0);
    chk("fl1_stall", bus.stall_o, 0);
    bus.stall_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("fl1_empty_v", bus.v_o, 0);

    // Flush while an issuable head is present suppresses the reservation.
    bus.rd_reserved_i = 1'b1;
    for (int k = 0; k < 3; k++) drive_push(mk_add(5'd1, 5'd2), 32'h500 + 32'(4 * k));
    bus.rd_reserved_i = 1'b0;
    bus.flush_i = 1'b1;
    bus.v_i = 1'b1;
    bus.origaddr_i = 32'h50C;
    #1;
    chk("fl2_rsv", bus.rd_reserve_o, 0);
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    bus.v_i = 1'b0;
    chk("fl2_v", bus.v_o, 0);
    chk("fl2_hcnt", bus.hazard_cnt_o, 6);
    repeat (2) @(posedge clk);
    #1;
    chk("fl2_empty_v", bus.v_o, 0);

    // Asynchronous reset with the queue full and an instruction issued.
    bus.stall_i = 1'b1;
    drive_push(mk_add(5'd1, 5'd2), 32'h600);
    @(posedge clk); #1;
    for (int k = 1; k < 5; k++) drive_push(mk_add(5'd1, 5'd2), 32'h600 + 32'(4 * k));
    chk("ar_pre_full", bus.stall_o, 1);
    chk("ar_pre_addr", bus.origaddr_o, 32'h600);
    bus.v_i = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("ar_v", bus.v_o, 0);
    chk("ar_stall", bus.stall_o, 0);
    chk("ar_addr", bus.origaddr_o, 0);
    chk("ar_src", bus.src_o, 0);
    chk("ar_hcnt", bus.hazard_cnt_o, 0);
    #2;
    bus.v_i = 1'b0;
    bus.stall_i = 1'b0;
    rst = 1'b1;
    drive_push(mk_add(5'd1, 5'd2), 32'h700);
    chk("ar_post_rsv", bus.rd_reserve_o, 1);
    @(posedge clk); #1;
    chk("ar_post_v", bus.v_o, 1);
    chk("ar_post_addr", bus.origaddr_o, 32'h700);
    chk("ar_post_src", bus.src_o, 32'h7);
    chk("ar_post_dest", bus.dest_o, 32'h5);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
